// File: rtl/mem_read_sequencer.sv
// mem_read_sequencer
//   Sequences block reads from the dual-port sample memory. On start it reads
//   a contiguous region two samples per cycle, with the even address on port A
//   and the odd address on port B. The sample pairs are streamed out over a
//   valid/ready interface that supports full backpressure.
//
//   Ports
//     clk, rst           clock; synchronous active-high reset
//     start              one-cycle pulse, sampled only in IDLE
//     base_addr          region start address (bit 0 ignored)
//     num_pairs          number of pairs to read, 0..1024
//     busy, done         transfer status / one-cycle completion pulse
//     addr_a, addr_b     registered memory addresses (even / odd)
//     q_a, q_b           memory read data, MEM_LAT cycles after the address
//     out_valid/ready    output handshake
//     out_data_a/b       sample pair (even / odd address)
//     out_last           marks the final pair of the transfer
//
//   Optional: define MEMSEQ_ABORT_EN to add the abort input and the sticky
//   aborted output.
module mem_read_sequencer #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_pairs,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] q_a,
    input  logic [DATA_W-1:0] q_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic              out_last
`ifdef MEMSEQ_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    localparam int DEPTH = MEM_LAT + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   issue_cnt, beat_cnt;
    logic [MEM_LAT-1:0]  vld_pipe;
    logic [MEM_LAT:0]    pipe_in;
    logic [DATA_W-1:0]   fifo_a [DEPTH];
    logic [DATA_W-1:0]   fifo_b [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt, inflight;
    logic [CNT_W:0]      occ;
    logic                accept, issue, push, pop, credit_ok, flush;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef MEMSEQ_ABORT_EN
    assign flush = abort && (state == RUN || state == DRAIN);
`else
    assign flush = 1'b0;
`endif

    assign addr_b     = addr_a | ADDR_W'(1);
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);
    assign out_valid  = (fifo_cnt != '0);
    assign out_data_a = out_valid ? fifo_a[rd_ptr] : '0;
    assign out_data_b = out_valid ? fifo_b[rd_ptr] : '0;
    assign out_last   = out_valid && (beat_cnt == ADDR_W'(1));
    assign pop        = out_valid && out_ready;
    assign push       = vld_pipe[MEM_LAT-1];
    assign pipe_in    = {vld_pipe, issue};

    // Reads in flight plus FIFO entries must leave room for one more read.
    // A pair leaving this cycle frees its slot, which sustains 1 pair/clk.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++)
            inflight = inflight + CNT_W'(vld_pipe[i]);
        occ       = (CNT_W+1)'(inflight) + (CNT_W+1)'(fifo_cnt) - (CNT_W+1)'(pop);
        credit_ok = occ < (CNT_W+1)'(DEPTH);
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        issue    = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept   = 1'b1;
                state_nx = (num_pairs != '0) ? RUN : FIN;
            end
            RUN: begin
                issue = (issue_cnt != '0) && credit_ok;
                if (issue && issue_cnt == ADDR_W'(1)) state_nx = DRAIN;
            end
            DRAIN: if (pop && beat_cnt == ADDR_W'(1)) state_nx = FIN;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            issue    = 1'b0;
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_a    <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            vld_pipe  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            state <= state_nx;
            // A zero-length start leaves the address untouched.
            if (accept && num_pairs != '0) begin
                addr_a    <= {base_addr[ADDR_W-1:1], 1'b0};
                issue_cnt <= num_pairs;
                beat_cnt  <= num_pairs;
            end else begin
                if (issue) begin
                    addr_a    <= addr_a + ADDR_W'(2);
                    issue_cnt <= issue_cnt - ADDR_W'(1);
                end
                if (pop) beat_cnt <= beat_cnt - ADDR_W'(1);
            end
            if (flush) begin
                vld_pipe <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                vld_pipe <= pipe_in[MEM_LAT-1:0];
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage needs no reset; the head is only visible while out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= q_a;
            fifo_b[wr_ptr] <= q_b;
        end
    end

`ifdef MEMSEQ_ABORT_EN
    always_ff @(posedge clk) begin
        if (rst)         aborted <= 1'b0;
        else if (accept) aborted <= 1'b0;
        else if (flush)  aborted <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Bench for mem_read_sequencer: memory model, expected-pair queue built from
// the region rules, and one negedge compare process.
module tb_mem_read_sequencer;
    localparam int AW = 11, DW = 8, ML = 1, DEPTH = ML + 1;

    logic clk = 1'b0, rst, start, out_ready;
    logic [AW-1:0] base_addr, num_pairs, addr_a, addr_b;
    logic [DW-1:0] q_a, q_b, out_data_a, out_data_b;
    logic busy, done, out_valid, out_last;
`ifdef MEMSEQ_ABORT_EN
    logic abort = 1'b0, aborted;
`endif

    mem_read_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(ML)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_pairs(num_pairs), .busy(busy), .done(done), .addr_a(addr_a),
        .addr_b(addr_b), .q_a(q_a), .q_b(q_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_data_a(out_data_a),
        .out_data_b(out_data_b), .out_last(out_last)
`ifdef MEMSEQ_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

    always #5 clk = ~clk;

    // memory with ML-cycle registered read
    logic [DW-1:0] mem [2048];
    logic [DW-1:0] qa_p [ML];
    logic [DW-1:0] qb_p [ML];
    always @(posedge clk) begin
        qa_p[0] <= mem[addr_a];
        qb_p[0] <= mem[addr_b];
        for (int i = 1; i < ML; i++) begin
            qa_p[i] <= qa_p[i-1];
            qb_p[i] <= qb_p[i-1];
        end
    end
    assign q_a = qa_p[ML-1];
    assign q_b = qb_p[ML-1];

    // ready driver: 0 = always, 1 = random, 2 = 1,0,0,1,0,1 pattern
    int rdy_mode = 0, pat_i = 0;
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       begin out_ready = 1'(pat[pat_i]); pat_i = (pat_i + 1) % 6; end
            default: out_ready = 1'b1;
        endcase
    end

    typedef struct { logic [7:0] a; logic [7:0] b; logic last; } pair_t;
    pair_t expq[$];
    logic [15:0] hs_log[$];
    int addr_log[$];
    bit m_busy = 0, m_done = 0, chk_busy = 0, prev_stall = 0;
    int m_hs = 0, m_n = 0, cyc = 0, acc_cyc = 0;
    int first_v = -1, first_hs = -1, last_hs = -1, done_cyc = -1, last_logged = -1;
    logic [AW-1:0] m_base = '0;
    logic [7:0] prev_a, prev_b;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit last_hit;
        logic [9:0] issued;
        last_hit = 0;
        cyc++;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("addr_b", 32'(addr_b), 32'(addr_a | 11'h1));
        if (out_valid && expq.size() == 0)
            chk("valid_unexpected", 32'(out_valid), 32'd0);
        if (out_valid && expq.size() != 0)
            chk("out_last", 32'(out_last), 32'(expq[0].last));
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", {16'h0, out_data_a, out_data_b}, {16'h0, prev_a, prev_b});
        end
        if (m_busy && m_n > 0) begin
            // reads issued so far follow from how far addr_a has moved
            issued = 10'((addr_a - m_base) >> 1);
            chk("outstanding_le_depth", 32'(10'(issued - 10'(m_hs)) <= 10'(DEPTH)), 32'd1);
            if (int'(addr_a) != last_logged) begin
                addr_log.push_back(int'(addr_a));
                last_logged = int'(addr_a);
            end
        end
        if (out_valid && first_v < 0) first_v = cyc;
        if (out_valid && out_ready && expq.size() != 0) begin
            pair_t e;
            e = expq.pop_front();
            chk("pair_data", {16'h0, out_data_a, out_data_b}, {16'h0, e.a, e.b});
            hs_log.push_back({out_data_a, out_data_b});
            m_hs++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            last_hit = e.last;
        end
        chk_busy = m_busy;
        if (m_done) begin
            done_cyc = cyc;
            m_done = 0;
            m_busy = 0;
        end
        if (last_hit) m_done = 1;
        prev_stall = out_valid && !out_ready;
        prev_a = out_data_a;
        prev_b = out_data_b;
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_pairs = n;
        @(posedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom); num_pairs = AW'($urandom);
        if (!chk_busy) begin
            m_busy = 1; m_base = b & ~11'h1; m_n = int'(n); m_hs = 0;
            acc_cyc = cyc; first_v = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
            addr_log.delete(); hs_log.delete(); last_logged = -1; prev_stall = 0;
            if (n == 0) m_done = 1;
            for (int i = 0; i < int'(n); i++) begin
                logic [AW-1:0] ad;
                pair_t p;
                ad = m_base + AW'(2 * i);
                p.a = mem[ad]; p.b = mem[ad | 11'h1]; p.last = (i == int'(n) - 1);
                expq.push_back(p);
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((m_busy || chk_busy) && t < 5000) begin @(posedge clk); t++; end
        chk("idle_timeout", 32'(t < 5000), 32'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_reset_vals();
        @(negedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr_a", 32'(addr_a), 32'h0);
        chk("rst_addr_b", 32'(addr_b), 32'h1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", {16'h0, out_data_a, out_data_b}, 32'h0);
    endtask

    initial begin
        logic [AW-1:0] a0;
        int t;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_pairs = '0; out_ready = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_vals();

        // basic 4-pair transfer
        do_start(11'h000, 11'd4);
        wait_idle();
        chk("t1_first_valid_lat", 32'(first_v - acc_cyc), 32'd3);
        chk("t1_consecutive", 32'(last_hs - first_hs), 32'd3);
        chk("t1_done_after_last", 32'(done_cyc - last_hs), 32'd1);
        chk("t1_count", 32'(m_hs), 32'd4);
        chk("t1_pair0", 32'(hs_log[0]), 32'h0001);
        chk("t1_pair3", 32'(hs_log[3]), 32'h0607);

        // address wrap
        do_start(11'h7FC, 11'd4);
        wait_idle();
        chk("t2_addr0", 32'(addr_log[0]), 32'h7FC);
        chk("t2_addr1", 32'(addr_log[1]), 32'h7FE);
        chk("t2_addr2", 32'(addr_log[2]), 32'h000);
        chk("t2_addr3", 32'(addr_log[3]), 32'h002);
        chk("t2_pair1", 32'(hs_log[1]), 32'hFEFF);
        chk("t2_pair2", 32'(hs_log[2]), 32'h0001);

        // backpressure pattern
        rdy_mode = 2; pat_i = 0;
        do_start(11'h100, 11'd4);
        wait_idle();
        rdy_mode = 0;
        chk("t3_count", 32'(m_hs), 32'd4);
        chk("t3_pair3", 32'(hs_log[3]), 32'h0607);

        // zero-length transfer
        a0 = addr_a;
        do_start(11'h300, 11'd0);
        wait_idle();
        chk("t4_done_lat", 32'(done_cyc - acc_cyc), 32'd1);
        chk("t4_addr_kept", 32'(addr_a), 32'(a0));
        chk("t4_no_valid", 32'(first_v), 32'hFFFF_FFFF);

        // reset mid-transfer, then a fresh short transfer
        do_start(11'h040, 11'd8);
        t = 0;
        while (m_hs < 2 && t < 200) begin @(posedge clk); t++; end
        chk("t5_hs_timeout", 32'(t < 200), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        expq.delete(); m_busy = 0; m_done = 0; chk_busy = 0; prev_stall = 0; m_n = 0;
        chk_reset_vals();
        do_start(11'h010, 11'd2);
        wait_idle();
        chk("t5_count", 32'(m_hs), 32'd2);
        chk("t5_pair0", 32'(hs_log[0]), 32'h1011);
        chk("t5_pair1", 32'(hs_log[1]), 32'h1213);

        // full 1024-pair sweep from an odd base; second start while busy ignored
        do_start(11'h005, 11'd1024);
        repeat (20) @(posedge clk);
        do_start(11'h200, 11'd5);
        wait_idle();
        chk("t6_count", 32'(m_hs), 32'd1024);
        chk("t6_pair0", 32'(hs_log[0]), 32'h0405);
        chk("t6_consecutive", 32'(last_hs - first_hs), 32'd1023);

        // randomized transfers over random memory contents
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        for (int it = 0; it < 20; it++) begin
            logic [AW-1:0] n;
            rdy_mode = $urandom_range(0, 2);
            n = AW'($urandom_range(0, 40));
            do_start(AW'($urandom), n);
            wait_idle();
            chk("rand_count", 32'(m_hs), 32'(n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
